axis_rr_mux: RTL and testbench
==============================

AXIS_RR_MUX -- requirements
Module: axis_rr_mux

Interface
REQ-001 SHALL have parameter N_PORTS, default 5, number of AXI-Stream input ports (2..16).
REQ-002 SHALL have parameter DATA_W, default 32, TDATA width.
REQ-003 SHALL have parameter ID_W, default 4, TID width.
REQ-004 SHALL have parameter DEST_W, default 4, TDEST width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries (power of 2, >=2).
REQ-006 SHALL have parameter CNT_W, default 16, PMU counter width.
REQ-007 SHALL provide ports, in this order:
- clk_i  in  1  clock; the block has one clock.
- rst_i  in  1  reset; asynchronous and active-high.
- s_tvalid_i  in  [N_PORTS]  input valid.
- s_tready_o  out  [N_PORTS]  input ready.
- s_tdata_i  in  [N_PORTS][DATA_W]  input data.
- s_tid_i  in  [N_PORTS][ID_W]  input ID.
- s_tdest_i  in  [N_PORTS][DEST_W]  input destination.
- s_tlast_i  in  [N_PORTS]  input end of packet.
- m_tvalid_o  out  1  output valid.
- m_tready_i  in  1  output ready.
- m_tdata_o  out  DATA_W  output data.
- m_tid_o  out  ID_W  output ID.
- m_tdest_o  out  DEST_W  output destination.
- m_tlast_o  out  1  output end of packet.
- grant_o  out  N_PORTS  one-hot locked input; all zero when idle.
- cnt_clear_i  in  1  synchronous PMU counter clear.
- pkt_cnt_o  out  [N_PORTS][CNT_W]  completed packets accepted per input.
- stall_cnt_o  out  CNT_W  output backpressure cycles.

Function
REQ-008 SHALL implement FSM states IDLE and LOCKED.
REQ-009 In IDLE with any s_tvalid_i high, SHALL pick the winner round-robin: first valid port after last_grant, wrapping modulo N_PORTS; at the next edge register grant_o and enter LOCKED.
REQ-010 In IDLE, all s_tready_o SHALL be 0; arbitration costs exactly one cycle per packet.
REQ-011 In LOCKED, s_tready_o[g] SHALL equal !fifo_full; all other s_tready_o SHALL be 0.
REQ-012 A beat SHALL be accepted when s_tvalid_i[g] and s_tready_o[g] are both high; {tdata, tid, tdest, tlast} are pushed into the FIFO.
REQ-013 An accepted beat with tlast=1 SHALL return the FSM to IDLE at that edge, set last_grant=g and clear grant_o.
REQ-014 Lock SHALL hold until tlast; a deasserted s_tvalid_i[g] mid-packet SHALL NOT release the lock.
REQ-015 m_tvalid_o SHALL equal !fifo_empty, with m_t* driven from the FIFO head (registered, no input-to-output combinational path).
REQ-016 Latency: a beat accepted at edge t SHALL be visible on m_tvalid_o in the cycle after edge t.
REQ-017 Simultaneous push and pop SHALL keep occupancy unchanged, including at full (pop frees slot same edge; s_tready_o still reflects pre-edge full).
REQ-018 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits, wrapping naturally; full/empty decided by MSB comparison.
REQ-019 pkt_cnt_o[i] SHALL increment on each accepted tlast beat from input i; stall_cnt_o SHALL increment each cycle with m_tvalid_o=1 and m_tready_i=0.
REQ-020 Counters SHALL saturate at 2^CNT_W-1.
REQ-021 cnt_clear_i SHALL zero all counters at the next edge; clear wins over a same-cycle increment.
REQ-022 No beat SHALL be dropped, duplicated or reordered; packets from different inputs SHALL never interleave on the output.

Reset
REQ-023 rst_i high SHALL asynchronously force: FSM=IDLE, FIFO empty, grant_o=0, last_grant=N_PORTS-1 (port 0 first), all counters 0.
REQ-024 During reset, s_tready_o=0, m_tvalid_o=0, m_t* data outputs=0.
REQ-025 Reset mid-packet SHALL discard the partial packet in the FIFO and the lock; no residual beat appears after release.

Verification
REQ-026 Port 2 sends 3-beat packet (data 0xA0..0xA2), m_tready_i=1 -> grant_o=0b00100 one cycle after s_tvalid_i, output beats 0xA0..0xA2 back-to-back, tlast on 0xA2, pkt_cnt_o[2]=1.
REQ-027 All 5 ports hold 1-beat packets continuously -> grant order 0,1,2,3,4,0; no port granted twice before all others.
REQ-028 m_tready_i=0, port 0 streams 6-beat packet, FIFO_DEPTH=4 -> s_tready_o[0] drops after 4 accepts, stall_cnt_o counts each held cycle; after m_tready_i=1 all 6 beats arrive in order.
REQ-029 Port 1 mid-packet with s_tvalid_i[1]=0 for 3 cycles while port 3 valid -> grant_o stays 0b00010; port 3 granted only after port 1 tlast.
REQ-030 rst_i pulsed after 2 of 4 beats accepted -> outputs clear immediately, m_tvalid_o=0 after release, next grant goes to port 0 when multiple ports are valid.
REQ-031 CNT_W=4, 20 one-beat packets on port 4 with cnt_clear_i pulsed on the 20th tlast -> pkt_cnt_o[4] saturates at 15, then reads 0.

Source files
------------

// File: rtl/axis_rr_mux.sv
// Round-robin AXI-Stream packet multiplexer: one input holds the lock from its first beat until tlast.
// Output beats come from a small registered FIFO; PMU counters track completed packets and output stalls.
module axis_rr_mux #(
  parameter int N_PORTS    = 5,
  parameter int DATA_W     = 32,
  parameter int ID_W       = 4,
  parameter int DEST_W     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [N_PORTS-1:0]               s_tvalid_i,
  output logic [N_PORTS-1:0]               s_tready_o,
  input  logic [N_PORTS-1:0][DATA_W-1:0]   s_tdata_i,
  input  logic [N_PORTS-1:0][ID_W-1:0]     s_tid_i,
  input  logic [N_PORTS-1:0][DEST_W-1:0]   s_tdest_i,
  input  logic [N_PORTS-1:0]               s_tlast_i,
  output logic                             m_tvalid_o,
  input  logic                             m_tready_i,
  output logic [DATA_W-1:0]                m_tdata_o,
  output logic [ID_W-1:0]                  m_tid_o,
  output logic [DEST_W-1:0]                m_tdest_o,
  output logic                             m_tlast_o,
  output logic [N_PORTS-1:0]               grant_o,
  input  logic                             cnt_clear_i,
  output logic [N_PORTS-1:0][CNT_W-1:0]    pkt_cnt_o,
  output logic [CNT_W-1:0]                 stall_cnt_o
);

  localparam int PW = $clog2(N_PORTS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + ID_W + DEST_W + 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                          state_q, state_d;
  logic [N_PORTS-1:0]              grant_q, grant_d;
  logic [PW-1:0]                   sel_q, sel_d;
  logic [PW-1:0]                   last_q, last_d;
  logic [PW-1:0]                   win_idx;
  logic                            win_found;
  logic [EW-1:0]                   mem_q [FIFO_DEPTH];
  logic [AW:0]                     wr_q, rd_q;
  logic                            full, empty, push, pop, push_last;
  logic [N_PORTS-1:0][CNT_W-1:0]   pkt_cnt_q;
  logic [CNT_W-1:0]                stall_cnt_q;

  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = (wr_q == rd_q);
  assign pop   = !empty && m_tready_i;

  // Search starts just after the last winner and wraps, so every requester is served within N_PORTS packets.
  always_comb begin
    int unsigned j;
    j         = 0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned k = 1; k <= N_PORTS; k++) begin
      j = (int'(last_q) + k) % N_PORTS;
      if (!win_found && s_tvalid_i[j]) begin
        win_found = 1'b1;
        win_idx   = PW'(j);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    last_d     = last_q;
    s_tready_o = '0;
    push       = 1'b0;
    push_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = LOCKED;
          sel_d   = win_idx;
          grant_d = N_PORTS'(1) << win_idx;
        end
      end
      LOCKED: begin
        s_tready_o[sel_q] = !full;
        push              = s_tvalid_i[sel_q] && !full;
        push_last         = push && s_tlast_i[sel_q];
        if (push_last) begin
          state_d = IDLE;
          last_d  = sel_q;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      last_q  <= PW'(N_PORTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  // Storage is reset too, so the head reads zero whenever the block is held in reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q[AW-1:0]] <= {s_tdata_i[sel_q], s_tid_i[sel_q], s_tdest_i[sel_q], s_tlast_i[sel_q]};
        wr_q                <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else if (cnt_clear_i) begin
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        if (push_last && grant_q[i] && pkt_cnt_q[i] != '1) pkt_cnt_q[i] <= pkt_cnt_q[i] + 1'b1;
      end
      if (!empty && !m_tready_i && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign {m_tdata_o, m_tid_o, m_tdest_o, m_tlast_o} = mem_q[rd_q[AW-1:0]];
  assign m_tvalid_o  = !empty;
  assign grant_o     = grant_q;
  assign pkt_cnt_o   = pkt_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_axis_rr_mux.sv
// Randomized and directed bench for axis_rr_mux against a queue-based packet-level reference model.
module tb_axis_rr_mux;
  localparam int N    = 5;
  localparam int DW   = 32;
  localparam int IW   = 4;
  localparam int DSW  = 4;
  localparam int FD   = 4;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  typedef struct packed {
    logic [DW-1:0]  d;
    logic [IW-1:0]  id;
    logic [DSW-1:0] dest;
    logic           last;
  } beat_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [N-1:0]            s_tvalid = '0;
  logic [N-1:0]            s_tready;
  logic [N-1:0][DW-1:0]    s_tdata = '0;
  logic [N-1:0][IW-1:0]    s_tid = '0;
  logic [N-1:0][DSW-1:0]   s_tdest = '0;
  logic [N-1:0]            s_tlast = '0;
  logic                    m_tvalid;
  logic                    m_tready = 1'b0;
  logic [DW-1:0]           m_tdata;
  logic [IW-1:0]           m_tid;
  logic [DSW-1:0]          m_tdest;
  logic                    m_tlast;
  logic [N-1:0]            grant;
  logic                    cnt_clear = 1'b0;
  logic [N-1:0][CW-1:0]    pkt_cnt;
  logic [CW-1:0]           stall_cnt;

  axis_rr_mux #(
    .N_PORTS(N), .DATA_W(DW), .ID_W(IW), .DEST_W(DSW), .FIFO_DEPTH(FD), .CNT_W(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .s_tvalid_i(s_tvalid), .s_tready_o(s_tready), .s_tdata_i(s_tdata),
    .s_tid_i(s_tid), .s_tdest_i(s_tdest), .s_tlast_i(s_tlast),
    .m_tvalid_o(m_tvalid), .m_tready_i(m_tready), .m_tdata_o(m_tdata),
    .m_tid_o(m_tid), .m_tdest_o(m_tdest), .m_tlast_o(m_tlast),
    .grant_o(grant), .cnt_clear_i(cnt_clear),
    .pkt_cnt_o(pkt_cnt), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  int    nchk = 0;
  int    npass = 0;
  beat_t srcq  [N][$];
  beat_t sentq [N][$];
  int    hold  [N];
  int    pv = 100;
  int    acc_port = -1;
  int    cur = -1;
  int    nout = 0;
  int    nsent = 0;
  int    tid_log [$];
  // reference model state
  beat_t mfifo [$];
  int    mlock = -1;
  int    mlast = N - 1;
  int    mpkt [N];
  int    mstall = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int winner();
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (mlast + k) % N;
      if (s_tvalid[j]) return j;
    end
    return -1;
  endfunction

  function automatic int model_acc();
    if (mlock >= 0 && s_tvalid[mlock] && mfifo.size() < FD) return mlock;
    return -1;
  endfunction

  task automatic add_pkt(input int p, input int len, input logic [DW-1:0] base, input bit rnd);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d    = rnd ? DW'($urandom) : base + DW'(k);
      b.id   = IW'(p);
      b.dest = DSW'($urandom);
      b.last = (k == len - 1);
      srcq[p].push_back(b);
      sentq[p].push_back(b);
      nsent++;
    end
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      if (hold[i] > 0) begin
        hold[i]--;
        s_tvalid[i] = 1'b0;
      end else if (!s_tvalid[i]) begin
        s_tvalid[i] = (srcq[i].size() > 0) && ($urandom_range(99) < pv);
      end
      if (srcq[i].size() > 0) {s_tdata[i], s_tid[i], s_tdest[i], s_tlast[i]} = srcq[i][0];
    end
  endtask

  task automatic capture();
    beat_t b, e;
    int p;
    b = {m_tdata, m_tid, m_tdest, m_tlast};
    p = int'(m_tid);
    nout++;
    tid_log.push_back(p);
    if (cur >= 0) chk("no_interleave", 64'(p), 64'(cur));
    if (p >= N || sentq[p].size() == 0) chk("no_extra_beat", 64'd1, 64'd0);
    else begin
      e = sentq[p].pop_front();
      chk("beat_order", 64'(b), 64'(e));
    end
    cur = b.last ? -1 : p;
  endtask

  task automatic step_core();
    logic [N-1:0]    er;
    logic [N*CW-1:0] ep;
    int              ap, w;
    @(negedge clk);
    er = '0;
    for (int i = 0; i < N; i++) if (mlock == i && mfifo.size() < FD) er[i] = 1'b1;
    chk("s_tready", 64'(s_tready), 64'(er));
    chk("grant", 64'(grant), mlock >= 0 ? (64'd1 << mlock) : 64'd0);
    chk("m_tvalid", 64'(m_tvalid), 64'(mfifo.size() > 0));
    if (mfifo.size() > 0) chk("m_beat", 64'({m_tdata, m_tid, m_tdest, m_tlast}), 64'(mfifo[0]));
    for (int i = 0; i < N; i++) ep[i*CW +: CW] = CW'(mpkt[i]);
    chk("pkt_cnt", 64'(pkt_cnt), 64'(ep));
    chk("stall_cnt", 64'(stall_cnt), 64'(mstall));
    if (m_tvalid && m_tready) capture();
    ap = model_acc();
    if (mfifo.size() > 0 && !m_tready && mstall < MAXC) mstall++;
    if (ap >= 0 && s_tlast[ap] && mpkt[ap] < MAXC) mpkt[ap]++;
    if (cnt_clear) begin
      mstall = 0;
      for (int i = 0; i < N; i++) mpkt[i] = 0;
    end
    if (mfifo.size() > 0 && m_tready) void'(mfifo.pop_front());
    if (ap >= 0) mfifo.push_back({s_tdata[ap], s_tid[ap], s_tdest[ap], s_tlast[ap]});
    if (mlock < 0) begin
      w = winner();
      if (w >= 0) mlock = w;
    end else if (ap >= 0 && s_tlast[ap]) begin
      mlast = ap;
      mlock = -1;
    end
    @(posedge clk);
    #1;
    if (ap >= 0) begin
      void'(srcq[ap].pop_front());
      s_tvalid[ap] = 1'b0;
    end
    acc_port = ap;
  endtask

  task automatic step();
    step_core();
    apply_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_tready", 64'(s_tready), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_mvalid", 64'(m_tvalid), 64'd0);
    chk("rst_mdata", 64'({m_tdata, m_tid, m_tdest, m_tlast}), 64'd0);
    chk("rst_cnts", 64'({pkt_cnt, stall_cnt}), 64'd0);
    for (int i = 0; i < N; i++) begin
      srcq[i].delete();
      sentq[i].delete();
      hold[i] = 0;
      mpkt[i] = 0;
    end
    s_tvalid = '0;
    mfifo.delete();
    tid_log.delete();
    mlock = -1; mlast = N - 1; mstall = 0;
    cur = -1; nout = 0; nsent = 0; acc_port = -1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rel_mvalid", 64'(m_tvalid), 64'd0);
    apply_inputs();
  endtask

  task automatic drain(input int maxc);
    bit done;
    m_tready = 1'b1;
    done = 1'b0;
    for (int k = 0; k < maxc && !done; k++) begin
      done = (mfifo.size() == 0) && (mlock < 0);
      for (int i = 0; i < N; i++) if (srcq[i].size() > 0) done = 1'b0;
      if (!done) step();
    end
    if (!done) chk("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #2;
    do_reset();

    // one 3-beat packet on port 2, sink always ready
    pv = 100; m_tready = 1'b1;
    add_pkt(2, 3, 32'hA0, 1'b0);
    apply_inputs();
    step();
    chk("t026_grant", 64'(grant), 64'b00100);
    drain(50);
    chk("t026_nout", 64'(nout), 64'd3);
    chk("t026_pkt", 64'(pkt_cnt[2]), 64'd1);

    // every port holds single-beat packets
    do_reset();
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) add_pkt(i, 1, 32'h0, 1'b1);
    apply_inputs();
    drain(100);
    for (int k = 0; k < 6; k++) chk("t027_order", 64'(tid_log[k]), 64'(k % N));

    // backpressure fills the buffer, then releases
    do_reset();
    m_tready = 1'b0;
    add_pkt(0, 6, 32'hB0, 1'b0);
    apply_inputs();
    for (int k = 0; k < 8; k++) step();
    chk("t028_tready", 64'(s_tready[0]), 64'd0);
    chk("t028_stall", 64'(stall_cnt), 64'd6);
    drain(50);
    chk("t028_nout", 64'(nout), 64'd6);

    // locked port goes quiet mid-packet while another port waits
    do_reset();
    m_tready = 1'b1;
    add_pkt(1, 4, 32'hC0, 1'b0);
    add_pkt(3, 2, 32'hD0, 1'b0);
    apply_inputs();
    for (int k = 0; k < 20 && acc_port != 1; k++) step_core();
    chk("t029_first_acc", 64'(acc_port), 64'd1);
    hold[1] = 3;
    apply_inputs();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t029_grant_hold", 64'(grant), 64'b00010);
    end
    drain(50);
    chk("t029_first_port", 64'(tid_log[0]), 64'd1);
    chk("t029_then_port3", 64'(tid_log[4]), 64'd3);

    // reset in the middle of a packet
    do_reset();
    m_tready = 1'b0;
    add_pkt(0, 4, 32'hE0, 1'b0);
    apply_inputs();
    begin
      int nacc;
      nacc = 0;
      for (int k = 0; k < 20 && nacc < 2; k++) begin
        step();
        if (acc_port == 0) nacc++;
      end
      chk("t030_two_acc", 64'(nacc), 64'd2);
    end
    do_reset();
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) add_pkt(i, 1, 32'hF0, 1'b1);
    apply_inputs();
    step();
    chk("t030_grant_port0", 64'(grant), 64'b00001);
    drain(50);
    chk("t030_nout", 64'(nout), 64'd3);

    // packet counter saturation and clear on the 20th packet
    do_reset();
    m_tready = 1'b1;
    for (int k = 0; k < 20; k++) add_pkt(4, 1, 32'h100, 1'b1);
    apply_inputs();
    begin
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 100 && !hit; k++) begin
        cnt_clear = (model_acc() == 4) && (srcq[4].size() == 1);
        if (cnt_clear) begin
          hit = 1'b1;
          chk("t031_sat", 64'(pkt_cnt[4]), 64'd15);
          step();
          chk("t031_clr", 64'(pkt_cnt[4]), 64'd0);
          cnt_clear = 1'b0;
        end else step();
      end
      chk("t031_reached", 64'(hit), 64'd1);
    end
    drain(50);

    // random traffic, random backpressure, occasional counter clears
    do_reset();
    pv = 60;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (srcq[i].size() < 8 && $urandom_range(7) == 0) add_pkt(i, $urandom_range(1, 6), 32'h0, 1'b1);
      m_tready  = ($urandom_range(99) < 70);
      cnt_clear = ($urandom_range(49) == 0);
      step();
    end
    cnt_clear = 1'b0;
    drain(1000);
    chk("rand_all_beats", 64'(nout), 64'(nsent));

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
